// File: rtl/bnn_inst_loader.sv
// Program loader and run sequencer for the BNN controller: streams a host program into the
// instruction SRAM, arms and releases the controller, and stops it once its PC passes the program end.
module bnn_inst_loader #(
    parameter int INST_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_run,
    input  logic              cfg_abort,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              host_valid,
    input  logic [INST_W-1:0] host_data,
    output logic              host_ready,
    input  logic              pause_req,
    input  logic [ADDR_W-1:0] ctrl_pc_addr,
    output logic              ctrl_rst,
    output logic              ctrl_pause,
    output logic [ADDR_W+1:0] instsram_ctrl,
    output logic [INST_W-1:0] instsram_wdata,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   wr_cnt;
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic [INST_W-1:0] wr_data;
    logic              err_q;

    logic accept_cfg;
    logic len_ok;
    logic start_go;
    logic start_bad;
    logic run_go;
    logic xfer;
    logic last_xfer;
    logic at_end;

    // Configuration pulses are only honoured while the controller is parked.
    assign accept_cfg = (state == IDLE) || (state == DONE);
    assign len_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN);
    assign start_go   = !cfg_abort && cfg_start && accept_cfg && len_ok;
    assign start_bad  = !cfg_abort && cfg_start && accept_cfg && !len_ok;
    assign run_go     = !cfg_abort && !cfg_start && cfg_run && accept_cfg && (len_q != '0);

    // Abort outranks the stream, so ready drops in the abort cycle itself.
    assign host_ready = (state == LOAD) && !cfg_abort;
    assign xfer       = host_valid && host_ready;
    assign last_xfer  = xfer && (wr_cnt == len_q - 1'b1);
    assign at_end     = {1'b0, ctrl_pc_addr} >= len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (cfg_abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_go) begin
                        state_nx = LOAD;
                    end else if (run_go) begin
                        state_nx = ARM;
                    end
                end
                LOAD: begin
                    if (last_xfer) begin
                        state_nx = ARM;
                    end
                end
                ARM: state_nx = RUN;
                RUN: begin
                    if (at_end) begin
                        state_nx = DONE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            wr_cnt  <= '0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            err_q   <= 1'b0;
        end else begin
            wr_pend <= xfer;
            if (xfer) begin
                wr_addr <= wr_cnt[ADDR_W-1:0];
                wr_data <= host_data;
                wr_cnt  <= wr_cnt + 1'b1;
            end
            if (cfg_abort) begin
                len_q <= '0;
            end else if (start_go) begin
                len_q  <= cfg_len;
                wr_cnt <= '0;
                err_q  <= 1'b0;
            end else if (start_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ctrl_rst       = 1'b1;
        ctrl_pause     = 1'b1;
        done           = 1'b0;
        instsram_wdata = wr_data;
        // A write registered in the last LOAD/ARM cycle is suppressed if an abort lands on it.
        if (wr_pend && !cfg_abort) begin
            instsram_ctrl = {1'b0, 1'b0, wr_addr};
        end else begin
            instsram_ctrl = {1'b1, 1'b1, {ADDR_W{1'b0}}};
        end
        case (state)
            RUN: begin
                ctrl_rst      = 1'b0;
                ctrl_pause    = pause_req;
                instsram_ctrl = {1'b1, 1'b0, ctrl_pc_addr};
            end
            DONE: begin
                ctrl_rst = 1'b0;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign err = err_q;

endmodule
